// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, width defaults
// and the starvation counter sizing helper.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_IFU_BUSY = 2'd1;
    localparam logic [1:0] ST_MAU_BUSY = 2'd2;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    // Counter must hold STARVE_LIMIT itself; never narrower than 3 bits.
    function automatic int starve_cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts consecutive MAU grants taken while the IFU waits and raises an
// override once STARVE_LIMIT is reached. Built only with ARB_STARVE_GUARD_EN.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_idle,
    input  logic i_ifu_req,
    input  logic i_ifu_grant,
    input  logic i_mau_grant,
    output logic o_override
);

    localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt >= LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_ifu_grant || (i_idle && !i_ifu_req)) begin
            r_cnt <= '0;
        end else if (i_mau_grant && i_ifu_req && !w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Only meaningful while the IFU is actually waiting.
    assign o_override = w_at_limit & i_ifu_req;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Single 32-bit memory port shared by IFU (fetch) and MAU (load/store); MAU has
// priority. Define ARB_STARVE_GUARD_EN to bound consecutive MAU wins over a waiting IFU.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_done,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              mau_req,
    input  logic              mau_we,
    input  logic [ADDR_W-1:0] mau_addr,
    input  logic [DATA_W-1:0] mau_wdata,
    output logic              mau_done,
    output logic [DATA_W-1:0] mau_rdata,
    output logic              mau_data_conflict,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    logic [1:0]        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_ifu_rdata;
    logic [DATA_W-1:0] r_mau_rdata;
    logic              r_ifu_done;
    logic              r_mau_done;

    logic w_idle;
    logic w_override;
    logic w_grant_mau;
    logic w_grant_ifu;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_grant_mau = w_idle & mau_req & ~w_override;
    assign w_grant_ifu = w_idle & ifu_req & ~w_grant_mau;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .i_idle      (w_idle),
        .i_ifu_req   (ifu_req),
        .i_ifu_grant (w_grant_ifu),
        .i_mau_grant (w_grant_mau),
        .o_override  (w_override)
    );
`else
    // Strict MAU priority: the limit has no effect, so the override is tied low.
    assign w_override = (STARVE_LIMIT < 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ifu_rdata <= '0;
            r_mau_rdata <= '0;
            r_ifu_done  <= 1'b0;
            r_mau_done  <= 1'b0;
        end else begin
            r_ifu_done <= 1'b0;
            r_mau_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_mau) begin
                        r_state     <= ST_MAU_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= mau_we;
                        r_mem_addr  <= mau_addr;
                        r_mem_wdata <= mau_wdata;
                    end else if (w_grant_ifu) begin
                        r_state    <= ST_IFU_BUSY;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= ifu_addr;
                    end
                end
                ST_IFU_BUSY: begin
                    if (mem_ready) begin
                        r_state     <= ST_IDLE;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_ifu_rdata <= mem_rdata;
                        r_ifu_done  <= 1'b1;
                    end
                end
                ST_MAU_BUSY: begin
                    if (mem_ready) begin
                        r_state    <= ST_IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mau_done <= 1'b1;
                        // Stores complete without touching the load data register.
                        if (!r_mem_we) begin
                            r_mau_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign mau_data_conflict = (r_state == ST_MAU_BUSY) | (w_idle & mau_req & ~w_override);

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ifu_rdata = r_ifu_rdata;
    assign mau_rdata = r_mau_rdata;
    assign ifu_done  = r_ifu_done;
    assign mau_done  = r_mau_done;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port between the instruction fetch unit (read-only) and the memory access unit (load/store).
- Owns the memory request/ready handshake and latches each winning transaction.
- Drives the fetch-side `data_already` and `MAU_data_conflict` qualifiers, so the fetch unit re-presents its PC while a data access holds the port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, maximum consecutive MAU grants while an IFU request waits. Used only with ARB_STARVE_GUARD_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ifu_req  in  1  fetch request, level; held until ifu_done.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_done  out  1  one-cycle pulse; ifu_rdata valid. Feeds `data_already`.
- ifu_rdata  out  DATA_W  fetched word, registered.
- mau_req  in  1  data request, level; held until mau_done.
- mau_we  in  1  1 = store, 0 = load.
- mau_addr  in  ADDR_W  data address.
- mau_wdata  in  DATA_W  store data.
- mau_done  out  1  one-cycle pulse on load data valid or store complete.
- mau_rdata  out  DATA_W  load data, registered.
- mau_data_conflict  out  1  high while the MAU owns or is claiming the port.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the current request this cycle.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including mem_req, mem_we, mem_addr, mem_wdata, both rdata registers, both done pulses and mau_data_conflict.
- FSM states: IDLE, IFU_BUSY, MAU_BUSY.
- IDLE:
  - mau_req = 1: go to MAU_BUSY. MAU wins simultaneous requests.
  - else ifu_req = 1: go to IFU_BUSY.
  - On the transition edge, latch mem_addr, mem_we and mem_wdata from the winner; mem_req rises.
  - mem_we is forced to 0 for IFU grants.
- Busy states:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - mem_req, mem_addr and mem_we are don't-care/0 when not busy; mem_wdata holds the last latched value and is stable only while busy.
  - Requester inputs are ignored after the grant edge.
- Completion (mem_ready = 1 in a busy state):
  - On that edge, mem_rdata is captured into the owner's rdata register (loads and fetches only; stores leave mau_rdata unchanged).
  - The owner's done pulses high for exactly one cycle.
  - mem_req falls, and the FSM returns to IDLE.
- Latency:
  - Grant edge to the first mem_req cycle: 1 cycle.
  - done asserts the cycle after mem_ready.
  - The next grant can occur on the edge after that. Minimum back-to-back spacing is 2 cycles per transaction when mem_ready is returned in the first request cycle.
- mem_ready while IDLE is ignored.
- mau_data_conflict is combinational: (state == MAU_BUSY) | (state == IDLE & mau_req).
- Requester dropping req before done: protocol violation. The transaction still completes and done still pulses.
- Reset mid-transaction:
  - Immediate return to IDLE, mem_req deasserted.
  - Any pending done pulses are discarded.
  - No retry.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A 3-bit-minimum counter counts consecutive MAU grants issued while ifu_req = 1.
  - When the count reaches STARVE_LIMIT, the next IDLE arbitration grants the IFU even if mau_req = 1.
  - While the override is active, mau_data_conflict is 0 for that arbitration cycle.
  - The counter clears on any IFU grant, on any IDLE cycle with ifu_req = 0, and on reset.
- Without the macro: strict MAU priority; the counter is absent.

Decomposition:
- Shared package holds:
  - The state encoding (IDLE = 2'd0, IFU_BUSY = 2'd1, MAU_BUSY = 2'd2).
  - The ADDR_W and DATA_W defaults.
  - STARVE_LIMIT's default.
- One sub-module is natural: arb_starve_counter (counter plus override flag), instantiated only under ARB_STARVE_GUARD_EN.
- The FSM and datapath registers stay in the top level.

Test Plan:
- Reset, then ifu_req = 1, ifu_addr = 0x00000010, mem_ready returned 2 cycles later with mem_rdata = 0x00500093:
  - mem_addr = 0x10 and mem_we = 0 one cycle after the request.
  - ifu_done pulses once with ifu_rdata = 0x00500093.
- Simultaneous ifu_req and mau_req (load at 0x00000100):
  - MAU granted first; mau_data_conflict = 1 until mau_done.
  - IFU is granted on the following IDLE arbitration.
- MAU store to 0x00000200 with mau_wdata = 0xDEADBEEF:
  - mem_we = 1 and mem_wdata = 0xDEADBEEF held until mem_ready.
  - mau_done pulses; mau_rdata is unchanged.
- Reset asserted during IFU_BUSY with mem_req = 1:
  - mem_req goes low asynchronously; no ifu_done pulse.
  - After release, a new request is granted normally.
- Requester changes ifu_addr to 0x20 mid-transaction: mem_addr stays 0x10 until completion.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT = 4, mau_req held high with ifu_req = 1:
  - The 5th arbitration grants the IFU.
  - Without the macro, the IFU is never granted while mau_req = 1.
